shift_counter_multi: RTL and testbench

//   Parametrised shift-register counter: ring (N states) or Johnson (2N states).

---
 rtl/shift_counter_pkg.sv | 18 +
 rtl/shift_counter_decode.sv | 41 ++++
 rtl/shift_counter_multi.sv | 139 +++++++++++++
 tb/tb_shift_counter_multi.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/shift_counter_pkg.sv
// Shared definitions for the shift-register counter family.
//   MODE_RING / MODE_JOHNSON : values of the run-time mode select
//   canonical(mode, n)       : the state a counter of width n starts from
package shift_counter_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;

   // Wide enough for any practical counter; callers cast down to their width.
   localparam int CANON_W = 64;

   // Ring starts with a single one in bit 0, Johnson starts all-zero.
   function automatic logic [CANON_W-1:0] canonical(input logic mode, input int n);
      canonical = '0;
      if (mode == MODE_RING && n >= 1) canonical[0] = 1'b1;
   endfunction

endpackage

// File: rtl/shift_counter_decode.sv
// Combinational state decoder for the shift-register counter.
//   count : counter state to classify
//   mode  : MODE_RING or MODE_JOHNSON
//   legal : count is one of the states of the sequence for this mode
//   phase : position of count in the sequence (0 when not legal)
// The decoder walks the sequence from the canonical state using the same
// left-step rule as the counter, so the decode can never drift from the
// stepping logic.
module shift_counter_decode
   import shift_counter_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = $clog2(2*N)
) (
   input  logic [N-1:0]  count,
   input  logic          mode,
   output logic          legal,
   output logic [PW-1:0] phase
);

   logic [N-1:0] pat;
   int           len;

   // NOTE: every variable written here gets a default first, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      legal = 1'b0;
      phase = '0;
      pat   = N'(canonical(mode, N));
      len   = (mode == MODE_RING) ? N : 2*N;
      for (int k = 0; k < 2*N; k++) begin
         if (k < len && !legal && count == pat) begin
            legal = 1'b1;
            phase = PW'(k);
         end
         if (mode == MODE_RING) pat = {pat[N-2:0], pat[N-1]};
         else                   pat = {pat[N-2:0], ~pat[N-1]};
      end
   end

endmodule

// File: rtl/shift_counter_multi.sv
// Ring / Johnson shift-register counter used as a phase or time-slot generator.
//   clk      : clock, all state changes on the rising edge
//   rst      : synchronous, active-high reset
//   en       : step enable
//   mode     : 0 = ring (N states), 1 = Johnson (2N states)
//   dir      : 0 = shift left / phase+1, 1 = shift right / phase-1
//   load     : parallel load strobe (ignores en)
//   load_val : value to load; illegal values load the canonical state
//   count    : registered counter state
//   phase    : registered sequence position, 0 = canonical state
//   wrap     : one-cycle pulse after a step across the phase boundary
//   illegal  : one-cycle pulse after a correction to the canonical state
// Edge priority: rst > load > mode change > step > hold.
module shift_counter_multi
   import shift_counter_pkg::*;
#(
   parameter  int N  = 4,
   localparam int PW = $clog2(2*N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          mode,
   input  logic          dir,
   input  logic          load,
   input  logic [N-1:0]  load_val,
   output logic [N-1:0]  count,
   output logic [PW-1:0] phase,
   output logic          wrap,
   output logic          illegal
);

   logic          mode_q;

   logic [N-1:0]  count_d;
   logic [PW-1:0] phase_d;
   logic          mode_d;
   logic          wrap_d;
   logic          illegal_d;

   logic [N-1:0]  canon_new;
   logic [PW-1:0] last_phase;
   logic          in_bit;

   logic          ld_legal;
   logic [PW-1:0] ld_phase;
   logic          cur_legal;
   logic [PW-1:0] cur_phase;

   // Load values are judged against the mode being requested this cycle.
   shift_counter_decode #(.N(N)) u_decode_load (
      .count (load_val),
      .mode  (mode),
      .legal (ld_legal),
      .phase (ld_phase)
   );

   // The live state is judged against the registered mode; the step path
   // derives the next phase from the decoded position rather than trusting
   // the phase register, so an upset in either is caught.
   shift_counter_decode #(.N(N)) u_decode_cur (
      .count (count),
      .mode  (mode_q),
      .legal (cur_legal),
      .phase (cur_phase)
   );

   always_comb begin
      canon_new  = N'(canonical(mode, N));
      last_phase = (mode_q == MODE_RING) ? PW'(N-1) : PW'(2*N-1);
      in_bit     = 1'b0;

      count_d    = count;
      phase_d    = phase;
      mode_d     = mode_q;
      wrap_d     = 1'b0;
      illegal_d  = 1'b0;

      if (load) begin
         mode_d = mode;
         if (ld_legal) begin
            count_d = load_val;
            phase_d = ld_phase;
         end else begin
            count_d   = canon_new;
            phase_d   = '0;
            illegal_d = 1'b1;
         end
      end else if (mode != mode_q) begin
         mode_d  = mode;
         count_d = canon_new;
         phase_d = '0;
      end else if (en) begin
         // mode == mode_q here, so canon_new is the canonical state of mode_q.
         if (!cur_legal) begin
            count_d   = canon_new;
            phase_d   = '0;
            illegal_d = 1'b1;
         end else if (!dir) begin
            in_bit  = (mode_q == MODE_JOHNSON) ? ~count[N-1] : count[N-1];
            count_d = {count[N-2:0], in_bit};
            if (cur_phase == last_phase) begin
               phase_d = '0;
               wrap_d  = 1'b1;
            end else begin
               phase_d = cur_phase + PW'(1);
            end
         end else begin
            in_bit  = (mode_q == MODE_JOHNSON) ? ~count[0] : count[0];
            count_d = {in_bit, count[N-1:1]};
            if (cur_phase == '0) begin
               phase_d = last_phase;
               wrap_d  = 1'b1;
            end else begin
               phase_d = cur_phase - PW'(1);
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= canon_new;
         phase   <= '0;
         mode_q  <= mode;
         wrap    <= 1'b0;
         illegal <= 1'b0;
      end else begin
         count   <= count_d;
         phase   <= phase_d;
         mode_q  <= mode_d;
         wrap    <= wrap_d;
         illegal <= illegal_d;
      end
   end

endmodule

// File: tb/tb_shift_counter_multi.sv
// Directed self-checking bench for shift_counter_multi (N = 4).
module tb_shift_counter_multi;

   localparam int N  = 4;
   localparam int PW = $clog2(2*N);

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          mode;
   logic          dir;
   logic          load;
   logic [N-1:0]  load_val;
   logic [N-1:0]  count;
   logic [PW-1:0] phase;
   logic          wrap;
   logic          illegal;

   int n_checks = 0;
   int n_errors = 0;

   shift_counter_multi #(.N(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .mode     (mode),
      .dir      (dir),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .phase    (phase),
      .wrap     (wrap),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One rising edge, then settle before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input int c, input int p,
                            input int w, input int il);
      check({tag, ".count"},   int'(count),   c);
      check({tag, ".phase"},   int'(phase),   p);
      check({tag, ".wrap"},    int'(wrap),    w);
      check({tag, ".illegal"}, int'(illegal), il);
   endtask

   int johnson_seq [8] = '{1, 3, 7, 15, 14, 12, 8, 0};
   int ring_down   [4] = '{8, 4, 2, 1};
   int ring_down_p [4] = '{3, 2, 1, 0};

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b1; dir = 1'b0; load = 1'b0; load_val = '0;
      tick();
      check_all("rst_johnson", 0, 0, 0, 0);

      // 1: Johnson forward full cycle
      rst = 1'b0; en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check_all($sformatf("t1_step%0d", i), johnson_seq[i], (i + 1) % 8,
                   (i == 7) ? 1 : 0, 0);
      end

      // 2: ring backward
      rst = 1'b1; mode = 1'b0; dir = 1'b1;
      tick();
      check_all("rst_ring", 1, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_all($sformatf("t2_step%0d", i), ring_down[i], ring_down_p[i],
                   (i == 0) ? 1 : 0, 0);
      end

      // 3: Johnson loads, legal then illegal
      en = 1'b0; dir = 1'b0; mode = 1'b1;
      tick();
      check_all("t3_modechg", 0, 0, 0, 0);
      load = 1'b1; load_val = 4'b0111;
      tick();
      check_all("t3_load_ok", 7, 3, 0, 0);
      load_val = 4'b0101;
      tick();
      check_all("t3_load_bad", 0, 0, 0, 1);
      load = 1'b0;
      tick();
      check_all("t3_hold", 0, 0, 0, 0);

      // 4: mode change Johnson -> ring with en=0
      load = 1'b1; load_val = 4'b0111;
      tick();
      check_all("t4_load", 7, 3, 0, 0);
      load = 1'b0; mode = 1'b0;
      tick();
      check_all("t4_to_ring", 1, 0, 0, 0);
      tick();
      check_all("t4_hold", 1, 0, 0, 0);

      // Ring loads: illegal multi-bit value, legal value, forward wrap
      load = 1'b1; load_val = 4'b0011;
      tick();
      check_all("ring_load_bad", 1, 0, 0, 1);
      load_val = 4'b0100;
      tick();
      check_all("ring_load_ok", 4, 2, 0, 0);
      load = 1'b0; en = 1'b1; dir = 1'b0;
      tick();
      check_all("ring_fwd1", 8, 3, 0, 0);
      tick();
      check_all("ring_fwd_wrap", 1, 0, 1, 0);

      // 5: rst wins over load and en mid-count
      tick();
      check_all("t5_pre", 2, 1, 0, 0);
      rst = 1'b1; load = 1'b1; load_val = 4'b1000;
      tick();
      check_all("t5_rst_wins", 1, 0, 0, 0);

      // 6: Johnson direction reversal across phase 0
      load = 1'b0; mode = 1'b1;
      tick();
      check_all("t6_rst", 0, 0, 0, 0);
      rst = 1'b0; dir = 1'b1;
      tick();
      check_all("t6_back", 8, 7, 1, 0);
      dir = 1'b0;
      tick();
      check_all("t6_fwd", 0, 0, 1, 0);
      en = 1'b0;
      tick();
      check_all("t6_idle", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
